// File: rtl/ark_mem_pkg.sv
// Shared constants and store-buffer entry type for the load/store unit.
// Imported by the store buffer and the mem_access_unit top.
package ark_mem_pkg;

  localparam int ADDR_W     = 16;
  localparam int DATA_W     = 16;
  localparam int MEM_DEPTH  = 256;
  localparam int SB_DEPTH   = 4;
  localparam int STARVE_MAX = 8;

  localparam int SB_PTR_W   = $clog2(SB_DEPTH);
  localparam int SB_CNT_W   = $clog2(SB_DEPTH + 1);
  localparam int STARVE_W   = $clog2(STARVE_MAX + 1);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } sb_entry_t;

endpackage

// File: rtl/mem_access_unit_store_buffer.sv
// In-order circular store buffer with a parallel youngest-match lookup.
// Reports whether the youngest match is the head entry.
import ark_mem_pkg::*;

module store_buffer (
  input  logic              CLK,
  input  logic              RST_n,
  input  logic              push,
  input  logic              pop,
  input  sb_entry_t         pushEntry,
  input  logic [ADDR_W-1:0] lookupAddr,
  output logic              full,
  output logic              empty,
  output sb_entry_t         head,
  output logic              hit,
  output logic              hitHead,
  output logic [DATA_W-1:0] hitData
);

  sb_entry_t               mem [SB_DEPTH];
  logic [SB_PTR_W-1:0]     headPtr;
  logic [SB_PTR_W-1:0]     tailPtr;
  logic [SB_CNT_W-1:0]     count;
  logic [SB_PTR_W-1:0]     idx;

  assign full  = (count == SB_CNT_W'(SB_DEPTH));
  assign empty = (count == '0);
  assign head  = mem[headPtr];

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      headPtr <= '0;
      tailPtr <= '0;
      count   <= '0;
    end else begin
      if (push) tailPtr <= tailPtr + 1'b1;
      if (pop)  headPtr <= headPtr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem[tailPtr] <= pushEntry;
  end

  // Walk oldest to youngest so the last match seen is the youngest.
  always_comb begin
    hit     = 1'b0;
    hitHead = 1'b0;
    hitData = '0;
    idx     = '0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      idx = headPtr + SB_PTR_W'(i);
      if (SB_CNT_W'(i) < count && mem[idx].addr == lookupAddr) begin
        hit     = 1'b1;
        hitHead = (i == 0);
        hitData = mem[idx].data;
      end
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit in front of DataRAM: request accept, SB forwarding,
// RAM port arbitration (load miss over drain), starvation guard, responses.
import ark_mem_pkg::*;

module mem_access_unit (
  input  logic              CLK,
  input  logic              RST_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              sb_empty,
  output logic [ADDR_W-1:0] DataAddress,
  output logic              ReadMem,
  output logic              WriteMem,
  output logic [DATA_W-1:0] DataIn,
  input  logic [DATA_W-1:0] DataOut
);

  logic                sbFull;
  logic                sbEmpty;
  logic                sbHit;
  logic                sbHitHead;
  logic [DATA_W-1:0]   sbHitData;
  sb_entry_t           sbHead;
  sb_entry_t           pushEntry;

  logic [STARVE_W-1:0] starveCnt;
  logic                forceDrain;
  logic                accept;
  logic                inRange;
  logic                isStore;
  logic                isLoad;
  logic                loadMiss;
  logic                headFwd;
  logic                drain;

  assign forceDrain = (starveCnt == STARVE_W'(STARVE_MAX));
  assign req_ready  = !sbFull && !forceDrain;
  assign accept     = req_valid && req_ready;
  assign inRange    = (req_addr < ADDR_W'(MEM_DEPTH));
  assign isStore    = accept && req_we && inRange;
  assign isLoad     = accept && !req_we && inRange;
  assign loadMiss   = isLoad && !sbHit;
  // Forwarding from the head holds it in place for this cycle.
  assign headFwd    = isLoad && sbHit && sbHitHead;
  assign drain      = !sbEmpty && !loadMiss && !headFwd;
  assign sb_empty   = sbEmpty;
  assign pushEntry  = '{addr: req_addr, data: req_wdata};

  store_buffer u_sb (
    .CLK        (CLK),
    .RST_n      (RST_n),
    .push       (isStore),
    .pop        (drain),
    .pushEntry  (pushEntry),
    .lookupAddr (req_addr),
    .full       (sbFull),
    .empty      (sbEmpty),
    .head       (sbHead),
    .hit        (sbHit),
    .hitHead    (sbHitHead),
    .hitData    (sbHitData)
  );

  always_comb begin
    ReadMem     = 1'b0;
    WriteMem    = 1'b0;
    DataAddress = '0;
    DataIn      = '0;
    unique case (1'b1)
      loadMiss: begin
        ReadMem     = 1'b1;
        DataAddress = req_addr;
      end
      drain: begin
        WriteMem    = 1'b1;
        DataAddress = sbHead.addr;
        DataIn      = sbHead.data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      starveCnt <= '0;
    end else if (drain) begin
      starveCnt <= '0;
    end else if (loadMiss && !sbEmpty) begin
      starveCnt <= starveCnt + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= accept;
      rsp_err   <= accept && !inRange;
      if (isLoad) rsp_data <= sbHit ? sbHitData : DataOut;
      else        rsp_data <= '0;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench: architectural memory model, pending-store queue,
// per-cycle port/ready checks and decoupled response monitor.
module tb_mem_access_unit;

  localparam int SBD = 4;
  localparam int SMX = 8;

  logic        CLK = 1'b0;
  logic        RST_n;
  logic        req_valid, req_ready, req_we;
  logic [15:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err, sb_empty;
  logic [15:0] rsp_data;
  logic [15:0] DataAddress, DataIn, DataOut;
  logic        ReadMem, WriteMem;

  mem_access_unit dut (
    .CLK         (CLK),
    .RST_n       (RST_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .rsp_err     (rsp_err),
    .sb_empty    (sb_empty),
    .DataAddress (DataAddress),
    .ReadMem     (ReadMem),
    .WriteMem    (WriteMem),
    .DataIn      (DataIn),
    .DataOut     (DataOut)
  );

  always #5 CLK = ~CLK;

  logic [15:0] ram  [256];
  logic [15:0] arch [256];

  assign DataOut = ReadMem ? ram[DataAddress[7:0]] : 16'hDEAD;

  always @(posedge CLK) begin
    if (WriteMem) ram[DataAddress[7:0]] <= DataIn;
  end

  typedef struct { logic [15:0] a; logic [15:0] d; } st_t;
  typedef struct { logic err; logic [15:0] d; } rsp_t;

  st_t  stq [$];
  rsp_t expq [$];
  int   hold = 0;
  int   vectors = 0;
  int   miscompares = 0;

  task automatic chk(string n, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (!RST_n) begin
      chk("reset_outputs",
          {rsp_valid, rsp_err, rsp_data, sb_empty, ReadMem, WriteMem,
           DataAddress, DataIn},
          {1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0});
      stq.delete();
      expq.delete();
      hold = 0;
      for (int i = 0; i < 256; i++) arch[i] = ram[i];
    end else begin
      int   occ, mi;
      bit   acc, inR, ld, miss, hh, expW, frc;
      logic [15:0] ea, ed;
      rsp_t r;
      if (expq.size() > 0) begin
        r = expq.pop_front();
        chk("rsp", {rsp_valid, rsp_err, rsp_data}, {1'b1, r.err, r.d});
      end else begin
        chk("rsp_idle", {63'd0, rsp_valid}, 64'd0);
      end
      occ = stq.size();
      chk("sb_empty", {63'd0, sb_empty}, {63'd0, occ == 0});
      frc = (hold == SMX);
      chk("req_ready", {63'd0, req_ready}, {63'd0, (occ < SBD) && !frc});
      acc = req_valid && req_ready;
      inR = req_addr < 16'd256;
      mi = -1;
      foreach (stq[i]) if (stq[i].a == req_addr) mi = i;
      ld   = acc && !req_we && inR;
      miss = ld && (mi < 0);
      hh   = ld && (mi == 0);
      expW = (occ > 0) && !miss && !hh;
      ea = miss ? req_addr : (expW ? stq[0].a : 16'h0);
      ed = expW ? stq[0].d : 16'h0;
      chk("ram_port", {ReadMem, WriteMem, DataAddress, DataIn},
          {miss, expW, ea, ed});
      if (WriteMem) begin
        if (occ > 0) void'(stq.pop_front());
        hold = 0;
      end else if (ReadMem && occ > 0) begin
        hold++;
      end
      if (acc) begin
        if (!inR)       expq.push_back('{1'b1, 16'h0});
        else if (req_we) expq.push_back('{1'b0, 16'h0});
        else            expq.push_back('{1'b0, arch[req_addr[7:0]]});
        if (req_we && inR) begin
          stq.push_back('{req_addr, req_wdata});
          arch[req_addr[7:0]] = req_wdata;
        end
      end
    end
  end

  task automatic issue(bit we, logic [15:0] a, logic [15:0] d);
    int n = 0;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    @(negedge CLK);
    while (!req_ready && n < 40) begin
      n++;
      @(negedge CLK);
    end
    if (!req_ready) chk("issue_timeout", {63'd0, req_ready}, 64'd1);
    @(posedge CLK);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic idle(int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic wait_empty();
    int n = 0;
    while (!sb_empty && n < 100) begin
      @(posedge CLK);
      #1;
      n++;
    end
    if (!sb_empty) chk("drain_timeout", {63'd0, sb_empty}, 64'd1);
  endtask

  initial begin
    int bad;
    RST_n     = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    for (int i = 0; i < 256; i++) ram[i] = 16'($urandom);
    ram[5] = 16'hBEEF;
    repeat (3) @(posedge CLK);
    #1 RST_n = 1'b1;
    idle(2);

    issue(1'b0, 16'h0005, 16'h0);
    issue(1'b1, 16'h0010, 16'h1234);
    issue(1'b0, 16'h0010, 16'h0);
    wait_empty();

    issue(1'b1, 16'h0020, 16'h1111);
    issue(1'b1, 16'h0020, 16'h2222);
    issue(1'b0, 16'h0020, 16'h0);
    wait_empty();
    idle(1);
    chk("ram_0x20", {48'd0, ram[8'h20]}, {48'd0, 16'h2222});

    for (int i = 0; i < 4; i++) issue(1'b1, 16'h0030 + 16'(i), 16'hA000 + 16'(i));
    for (int i = 0; i < 14; i++) issue(1'b0, 16'h0040 + 16'(i), 16'h0);
    wait_empty();

    issue(1'b0, 16'h0100, 16'h0);
    issue(1'b1, 16'hFFFF, 16'h5555);
    idle(2);

    for (int i = 0; i < 3; i++) issue(1'b1, 16'h0050 + 16'(i), 16'hC000 + 16'(i));
    RST_n = 1'b0;
    idle(2);
    RST_n = 1'b1;
    idle(4);

    for (int k = 0; k < 400; k++) begin
      int r;
      logic [15:0] a;
      r = $urandom_range(0, 9);
      if (r == 0)     a = 16'($urandom_range(256, 65535));
      else if (r < 4) a = 16'h0080 + 16'($urandom_range(0, 15));
      else            a = 16'($urandom_range(0, 7));
      issue(1'($urandom_range(0, 1)), a, 16'($urandom));
      if ($urandom_range(0, 3) == 0) idle(1);
    end

    wait_empty();
    idle(2);
    bad = 0;
    for (int i = 0; i < 256; i++) if (ram[i] !== arch[i]) bad++;
    chk("ram_final", 64'(bad), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
